// File: rtl/pcd_rx_decoder.sv
// PCD-side Manchester receiver for 106 kbps load-modulated PICC responses.
// Optional odd-parity checking is enabled by defining PCD_RX_PARITY_CHECK_EN.
module pcd_rx_decoder #(
  parameter int unsigned SAMPLE_WIDTH = 32,
  parameter int unsigned HALF_LEN     = 64,
  parameter int unsigned THRESH       = 1024,
  parameter int unsigned MIN_HITS     = 16,
  parameter int unsigned MAX_BYTES    = 5
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            s00_axis_tvalid,
  input  logic [SAMPLE_WIDTH-1:0]         s00_axis_tdata,
  output logic                            s00_axis_tready,
  output logic [8*MAX_BYTES-1:0]          data_out,
  output logic [$clog2(MAX_BYTES+1)-1:0]  num_bytes_out,
  output logic                            valid_out,
  output logic                            err_out,
  output logic                            parity_err_out,
  output logic                            busy_out
);

  localparam int unsigned CW  = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
  localparam int unsigned HW  = $clog2(HALF_LEN + 1);
  localparam int unsigned NBW = $clog2(MAX_BYTES + 1);
  localparam logic [SAMPLE_WIDTH:0] THRESH_W = (SAMPLE_WIDTH + 1)'(THRESH);

  typedef enum logic [1:0] {StIdle, StSof, StBits} state_e;

  state_e                 state_q;
  logic [CW-1:0]          samp_cnt_q;
  logic [HW-1:0]          hit_cnt_q;
  logic                   half_q;
  logic                   first_mod_q;
  logic [3:0]             bit_idx_q;
  logic [7:0]             cur_byte_q;
  logic [8*MAX_BYTES-1:0] stage_q;
  logic [NBW-1:0]         stage_cnt_q;
  logic                   par_flag_q;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [NBW-1:0]         num_bytes_q;
  logic                   valid_q;
  logic                   err_q;
  logic                   perr_q;
  logic                   busy_q;

  logic                    accept;
  logic signed [SAMPLE_WIDTH:0] x_ext;
  logic [SAMPLE_WIDTH:0]   abs_x;
  logic                    hit;
  logic [HW-1:0]           hit_sum;
  logic                    win_last;
  logic                    win_mod;
  logic                    sym_bit;
  logic                    par_fail;

  assign s00_axis_tready = ~rst_in;
  assign accept          = s00_axis_tvalid & ~rst_in;

  always_comb begin
    // One extra bit keeps |most negative| representable.
    x_ext    = {s00_axis_tdata[SAMPLE_WIDTH-1], s00_axis_tdata};
    abs_x    = x_ext[SAMPLE_WIDTH] ? (SAMPLE_WIDTH + 1)'(-x_ext) : x_ext;
    hit      = abs_x > THRESH_W;
    hit_sum  = hit_cnt_q + HW'(hit);
    win_last = samp_cnt_q == CW'(HALF_LEN - 1);
    win_mod  = hit_sum >= HW'(MIN_HITS);
    sym_bit  = first_mod_q;
`ifdef PCD_RX_PARITY_CHECK_EN
    par_fail = ~(^{cur_byte_q, sym_bit});
`else
    par_fail = 1'b0;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      samp_cnt_q  <= '0;
      hit_cnt_q   <= '0;
      half_q      <= 1'b0;
      first_mod_q <= 1'b0;
      bit_idx_q   <= '0;
      cur_byte_q  <= '0;
      stage_q     <= '0;
      stage_cnt_q <= '0;
      par_flag_q  <= 1'b0;
      data_q      <= '0;
      num_bytes_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
      if (accept) begin
        unique case (state_q)
          StIdle: begin
            // The first hit is sample 0 of the SOF first half.
            if (hit) begin
              state_q     <= StSof;
              busy_q      <= 1'b1;
              samp_cnt_q  <= CW'(1);
              hit_cnt_q   <= HW'(1);
              half_q      <= 1'b0;
              bit_idx_q   <= '0;
              cur_byte_q  <= '0;
              stage_q     <= '0;
              stage_cnt_q <= '0;
              par_flag_q  <= 1'b0;
            end
          end
          default: begin
            if (!win_last) begin
              samp_cnt_q <= samp_cnt_q + CW'(1);
              hit_cnt_q  <= hit_sum;
            end else begin
              samp_cnt_q <= '0;
              hit_cnt_q  <= '0;
              if (!half_q) begin
                half_q      <= 1'b1;
                first_mod_q <= win_mod;
              end else begin
                half_q <= 1'b0;
                if (state_q == StSof) begin
                  if (first_mod_q && !win_mod) begin
                    state_q <= StBits;
                  end else begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                  end
                end else if (first_mod_q && win_mod) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
                end else if (!first_mod_q && !win_mod) begin
                  // EOF: only a byte-aligned, non-empty frame is good.
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
                  if (bit_idx_q == 4'd0 && stage_cnt_q != '0) begin
                    valid_q     <= 1'b1;
                    perr_q      <= par_flag_q;
                    data_q      <= stage_q;
                    num_bytes_q <= stage_cnt_q;
                  end else begin
                    err_q <= 1'b1;
                  end
                end else if (bit_idx_q == 4'd8) begin
                  if (stage_cnt_q == NBW'(MAX_BYTES)) begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                  end else begin
                    for (int i = 0; i < int'(MAX_BYTES); i++) begin
                      if (stage_cnt_q == NBW'(i)) stage_q[8*i +: 8] <= cur_byte_q;
                    end
                    stage_cnt_q <= stage_cnt_q + NBW'(1);
                    bit_idx_q   <= '0;
                    if (par_fail) par_flag_q <= 1'b1;
                  end
                end else begin
                  cur_byte_q <= {sym_bit, cur_byte_q[7:1]};
                  bit_idx_q  <= bit_idx_q + 4'd1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign data_out       = data_q;
  assign num_bytes_out  = num_bytes_q;
  assign valid_out      = valid_q;
  assign err_out        = err_q;
  assign parity_err_out = perr_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_pcd_rx_decoder.sv
// Scoreboard bench for pcd_rx_decoder: frames are synthesised as sine/zero half-windows.
module tb_pcd_rx_decoder;

  localparam int unsigned SW  = 32;
  localparam int unsigned HL  = 8;
  localparam int unsigned TH  = 1024;
  localparam int unsigned MH  = 4;
  localparam int unsigned MB  = 5;
  localparam int unsigned NBW = $clog2(MB + 1);
`ifdef PCD_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            s00_axis_tvalid = 1'b0;
  logic [SW-1:0]   s00_axis_tdata = '0;
  logic            s00_axis_tready;
  logic [8*MB-1:0] data_out;
  logic [NBW-1:0]  num_bytes_out;
  logic            valid_out;
  logic            err_out;
  logic            parity_err_out;
  logic            busy_out;

  always #5 clk_in = ~clk_in;

  pcd_rx_decoder #(
    .SAMPLE_WIDTH(SW),
    .HALF_LEN    (HL),
    .THRESH      (TH),
    .MIN_HITS    (MH),
    .MAX_BYTES   (MB)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tdata (s00_axis_tdata),
    .s00_axis_tready(s00_axis_tready),
    .data_out       (data_out),
    .num_bytes_out  (num_bytes_out),
    .valid_out      (valid_out),
    .err_out        (err_out),
    .parity_err_out (parity_err_out),
    .busy_out       (busy_out)
  );

  typedef struct {
    bit              is_err;
    logic [8*MB-1:0] data;
    int              nbytes;
    bit              perr;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              checks = 0;
  int              failures = 0;
  bit              gaps = 1'b0;
  logic [8*MB-1:0] last_data = '0;
  int              last_n = 0;
  int              sine[8] = '{7654, 18478, 18478, 7654, -7654, -18478, -18478, -7654};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] byte_mask(input int n);
    return (n == 0) ? 64'd0 : ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (valid_out || err_out || parity_err_out) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {61'd0, valid_out, err_out, parity_err_out}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("valid", 64'(valid_out), 64'(!mon_e.is_err));
        check("err", 64'(err_out), 64'(mon_e.is_err));
        check("parity_err", 64'(parity_err_out), 64'(mon_e.perr));
        check("num_bytes", 64'(num_bytes_out), 64'(mon_e.nbytes));
        check("data", 64'(data_out) & byte_mask(mon_e.nbytes),
              64'(mon_e.data) & byte_mask(mon_e.nbytes));
        check("busy_drop", 64'(busy_out), 64'd0);
      end
    end
  end

  task automatic drive_sample(input int x);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        s00_axis_tvalid = 1'b0;
        s00_axis_tdata  = 32'd30000;
        @(posedge clk_in); #1;
      end
    end
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = x;
    @(posedge clk_in); #1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tdata  = '0;
  endtask

  task automatic half(input bit m);
    for (int k = 0; k < int'(HL); k++) drive_sample(m ? sine[k] : 0);
  endtask

  task automatic sym(input bit b);
    half(b);
    half(!b);
  endtask

  task automatic sof();
    half(1'b1);
    half(1'b0);
  endtask

  task automatic eof();
    half(1'b0);
    half(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit inv);
    for (int i = 0; i < 8; i++) sym(b[i]);
    sym(~(^b) ^ inv);
  endtask

  task automatic expect_good(input logic [8*MB-1:0] d, input int n, input bit perr);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.nbytes = n;
    e.perr   = perr;
    sb.push_back(e);
    last_data = d;
    last_n    = n;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_data;
    e.nbytes = last_n;
    e.perr   = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk_in); #1;
    end
    check(tag, 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [7:0] four[4];
    four = '{8'h35, 8'h67, 8'h90, 8'h24};

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_tready", 64'(s00_axis_tready), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);
    check("rst_perr", 64'(parity_err_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_nbytes", 64'(num_bytes_out), 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("tready_up", 64'(s00_axis_tready), 64'd1);
    @(posedge clk_in); #1;

    // Four good bytes.
    expect_good(40'h0024906735, 4, 1'b0);
    sof();
    foreach (four[i]) send_byte(four[i], 1'b0);
    eof();
    drain("frame4_drain");

    // Byte 1 parity inverted.
    expect_good(40'h0024906735, 4, PAR_EN);
    sof();
    foreach (four[i]) send_byte(four[i], i == 1);
    eof();
    drain("badpar_drain");

    // EOF after four data bits.
    expect_err();
    sof();
    for (int i = 0; i < 4; i++) sym(i[0]);
    eof();
    drain("midbyte_drain");

    // (M,M) coding error, then clean recovery frame.
    expect_err();
    sof();
    @(negedge clk_in);
    check("busy_in_frame", 64'(busy_out), 64'd1);
    @(posedge clk_in); #1;
    half(1'b1);
    half(1'b1);
    @(negedge clk_in);
    check("busy_after_err", 64'(busy_out), 64'd0);
    @(posedge clk_in); #1;
    drain("mm_drain");
    expect_good(40'h00000000A5, 1, 1'b0);
    sof();
    send_byte(8'hA5, 1'b0);
    eof();
    drain("a5_drain");

    // Overflow: six bytes into a five-byte buffer.
    expect_err();
    sof();
    for (int i = 0; i < 6; i++) send_byte(8'h11 * (i + 1), 1'b0);
    eof();
    drain("ovf_drain");

    // 16'hBEEF continuous and with random tvalid gaps.
    for (int g = 0; g < 2; g++) begin
      gaps = (g == 1);
      expect_good(40'h000000BEEF, 2, 1'b0);
      sof();
      send_byte(8'hEF, 1'b0);
      send_byte(8'hBE, 1'b0);
      eof();
      drain(gaps ? "beef_gap_drain" : "beef_drain");
    end
    gaps = 1'b0;

    // Reset mid-frame: no strobe, tready low, outputs cleared.
    sof();
    for (int i = 0; i < 3; i++) sym(1'b1);
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    check("midrst_tready", 64'(s00_axis_tready), 64'd0);
    check("midrst_busy", 64'(busy_out), 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_data", 64'(data_out), 64'd0);
    check("midrst_nbytes", 64'(num_bytes_out), 64'd0);
    @(posedge clk_in); #1;
    last_data = '0;
    last_n    = 0;
    expect_good(40'h000000005A, 1, 1'b0);
    sof();
    send_byte(8'h5A, 1'b0);
    eof();
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pcd_rx_decoder.md
Name: pcd_rx_decoder

Overview:
- Reader-side (PCD) receiver for PICC-to-PCD load-modulated responses, ISO 14443A-style Manchester coding at 106 kbps.
- Consumes the signed sample stream produced by the PICC transmit path (amplitude gate × sine).
- Detects modulation energy per half-bit window, decodes SOF, data and parity bits, and EOF.
- Presents up to MAX_BYTES received bytes with valid, error and parity-error strobes.

Parameters:
- SAMPLE_WIDTH, 32: width of s00_axis_tdata, signed samples.
- HALF_LEN, 64: accepted samples per half-bit window.
- THRESH, 1024: a sample is a "hit" when |sample| > THRESH.
- MIN_HITS, 16: a half-window is "modulated" when its hit count ≥ MIN_HITS.
- MAX_BYTES, 5: maximum frame length in bytes.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- s00_axis_tvalid  input  1  sample valid
- s00_axis_tdata  input  SAMPLE_WIDTH  signed sample
- s00_axis_tready  output  1  sample accept; 0 during reset, otherwise 1
- data_out  output  8*MAX_BYTES  received bytes; byte 0 in [7:0], each byte LSB-first on air
- num_bytes_out  output  $clog2(MAX_BYTES+1)  byte count of the last good frame
- valid_out  output  1  one-cycle pulse, good frame
- err_out  output  1  one-cycle pulse, coding, framing or overflow error
- parity_err_out  output  1  one-cycle pulse coincident with valid_out when any byte failed odd parity
- busy_out  output  1  high from SOF detection until frame end

Behaviour:
- Reset values:
  - All outputs 0, including data_out and num_bytes_out.
  - s00_axis_tready is 0 during reset.
  - State returns to IDLE and all counters clear.
  - Reset mid-frame discards the frame and emits no strobe.
- Sample processing:
  - Only accepted samples (tvalid & tready) advance anything.
  - |x| is computed with one extra bit, so the most negative value does not overflow.
  - hit = |x| > THRESH.
- State IDLE:
  - Waits for the first hit. That sample is sample 0 of the SOF first half.
  - On this transition busy_out goes to 1, and the half-sample and hit counters are loaded (hit count = 1).
- Half-window classification:
  - Each half-window spans HALF_LEN accepted samples.
  - On its last sample the window is classified M (modulated) or U (unmodulated) using the hit count including that sample.
  - Counters then restart for the next window.
- State SOF:
  - Requires first half M and second half U.
  - Second half M → coding error.
- State BITS: decodes one symbol per half-window pair.
  - (M,U) = 1
  - (U,M) = 0
  - (U,U) = EOF
  - (M,M) = coding error
- Bit framing:
  - Bits 0–7 are data, shifted LSB-first into the current byte. Bit 8 is parity.
  - At parity, the byte is committed to staging. A parity failure sets a sticky flag.
  - Committing a byte when MAX_BYTES bytes are already staged → overflow error.
- EOF handling:
  - Good frame: EOF arrives with bit index 0 and at least 1 byte staged.
    - On the cycle after the EOF second-half sample: copy staging to data_out, set num_bytes_out, pulse valid_out, pulse parity_err_out if the flag is set.
  - Any other EOF (mid-byte, or zero bytes) → framing error.
- On any error:
  - err_out pulses on the cycle after the offending sample.
  - data_out and num_bytes_out keep their previous values.
- After a good frame or an error: busy_out drops with the strobe, state returns to IDLE, and the block is ready the next cycle.
- Strobes are never asserted simultaneously with each other, except parity_err_out together with valid_out.
- tvalid gaps: counters hold and there is no timeout.

Optional Feature:
- Macro: PCD_RX_PARITY_CHECK_EN.
- Defined: parity bits are checked for odd parity, the sticky flag is kept, and parity_err_out is driven as specified.
- Undefined: parity bits are consumed and ignored, and parity_err_out is tied to 0.
- Framing and byte counting are identical in both builds.

Test Plan (HALF_LEN=8, MIN_HITS=4, THRESH=1024; M half = 8 samples of ±20000 sine, U half = 8 zeros):
- Bytes 35,67,90,24 with correct odd parity, SOF + EOF → valid_out once, data_out[31:0]=32'h24906735, num_bytes_out=4, err_out=0, parity_err_out=0.
- Same frame with byte 1's parity inverted → valid_out and parity_err_out in the same cycle, data_out=32'h24906735 (parity_err_out=0 when the macro is undefined).
- SOF, 4 data bits, then EOF → err_out pulse, no valid_out, data_out still holds the previous frame.
- SOF then an (M,M) symbol → err_out pulse, busy_out=0 the next cycle, and a following clean 1-byte frame 8'hA5 decodes correctly.
- Six-byte frame with MAX_BYTES=5 → err_out at the sixth parity bit, no valid_out.
- tvalid toggled 50% random during a 2-byte frame 16'hBEEF → same result as continuous. rst_in asserted mid-frame → no strobe and tready=0 during reset.
